// File: rtl/step_checker_pkg.sv
// rtl/step_checker_pkg.sv - shared encodings, state type and helpers for step_checker
package step_checker_pkg;

   // Expected-event kinds stored in the table
   localparam logic [1:0] KIND_REG  = 2'd0;
   localparam logic [1:0] KIND_MEM  = 2'd1;
   localparam logic [1:0] KIND_PC   = 2'd2;
   localparam logic [1:0] KIND_NONE = 2'd3;

   // Width of the saturating error counter
   localparam int ERR_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STEP,
      S_WAIT,
      S_CHECK,
      S_ADVANCE,
      S_DONE
   } state_t;

   // Increment that sticks at all-ones
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

endpackage

// File: rtl/step_checker_if.sv
// rtl/step_checker_if.sv - stepping and observation bus between checker and core
interface step_checker_if #(
   parameter int DATA_WIDTH = 16,
   parameter int PC_WIDTH   = 16,
   parameter int REG_AW     = 3
);
   logic                  step_en;
   logic                  commit;
   logic                  rf_we;
   logic [REG_AW-1:0]     rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;
   logic                  dm_we;
   logic [PC_WIDTH-1:0]   dm_addr;
   logic [DATA_WIDTH-1:0] dm_wdata;
   logic [PC_WIDTH-1:0]   pc_next;

   // Checker side: issues step enables, observes the core's buses
   modport master (
      output step_en,
      input  commit, rf_we, rf_waddr, rf_wdata, dm_we, dm_addr, dm_wdata, pc_next
   );

   // Core side: receives step enables, reports retirement effects
   modport slave (
      input  step_en,
      output commit, rf_we, rf_waddr, rf_wdata, dm_we, dm_addr, dm_wdata, pc_next
   );
endinterface

// File: rtl/step_expect_ram.sv
// rtl/step_expect_ram.sv - expected-event table, sync write, async read, no reset
module step_expect_ram #(
   parameter int DEPTH      = 16,
   parameter int PC_WIDTH   = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [1:0]                 wkind,
   input  logic [PC_WIDTH-1:0]        widx,
   input  logic [DATA_WIDTH-1:0]      wvalue,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [1:0]                 rkind,
   output logic [PC_WIDTH-1:0]        ridx,
   output logic [DATA_WIDTH-1:0]      rvalue
);
   localparam int EW = 2 + PC_WIDTH + DATA_WIDTH;

   logic [EW-1:0] mem [DEPTH];

   // Table write; deliberately unreset so a loaded table survives reset_n
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= {wkind, widx, wvalue};
      end
   end

   assign {rkind, ridx, rvalue} = mem[raddr];
endmodule

// File: rtl/step_checker.sv
// rtl/step_checker.sv - single-step driver that checks each retired instruction against a table
module step_checker
   import step_checker_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int PC_WIDTH   = 16,
   parameter int REG_AW     = 3,
   parameter int DEPTH      = 16,
   parameter int TIMEOUT    = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       exp_we,
   input  logic [$clog2(DEPTH)-1:0]   exp_addr,
   input  logic [1:0]                 exp_kind,
   input  logic [PC_WIDTH-1:0]        exp_idx,
   input  logic [DATA_WIDTH-1:0]      exp_value,
   input  logic                       start,
   input  logic [$clog2(DEPTH):0]     num_steps,
   input  logic                       stop_on_fail,
   step_checker_if.master             core,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [ERR_W-1:0]           err_count,
   output logic [$clog2(DEPTH)-1:0]   fail_step
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   DEPTH_N    = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   state_t                state, state_nx;
   logic [AW:0]           n_steps, n_start, step, step_inc;
   logic [TW-1:0]         timer;
   logic                  stop_mode, step_err;
   logic                  accept_start, got_commit, timed_out, match, record_err;

   logic                  cap_rf_we, cap_dm_we;
   logic [REG_AW-1:0]     cap_rf_waddr;
   logic [DATA_WIDTH-1:0] cap_rf_wdata, cap_dm_wdata;
   logic [PC_WIDTH-1:0]   cap_dm_addr, cap_pc;

   logic [1:0]            ent_kind;
   logic [PC_WIDTH-1:0]   ent_idx;
   logic [DATA_WIDTH-1:0] ent_value;

   step_expect_ram #(
      .DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .DATA_WIDTH(DATA_WIDTH)
   ) u_ram (
      .clk(clk), .we(exp_we && !busy), .waddr(exp_addr),
      .wkind(exp_kind), .widx(exp_idx), .wvalue(exp_value),
      .raddr(step[AW-1:0]), .rkind(ent_kind), .ridx(ent_idx), .rvalue(ent_value)
   );

   assign busy         = (state != S_IDLE) && (state != S_DONE);
   assign done         = (state == S_DONE);
   assign pass         = done && (err_count == '0);
   assign core.step_en = (state == S_STEP);

   assign accept_start = start && !busy;
   assign n_start      = (num_steps > DEPTH_N) ? DEPTH_N : num_steps;
   assign step_inc     = step + (AW+1)'(1);
   assign got_commit   = (state == S_WAIT) && core.commit;
   // A commit on the last allowed cycle wins over the timeout
   assign timed_out    = (state == S_WAIT) && !core.commit && (timer == TIMER_LAST);
   assign record_err   = ((state == S_CHECK) && !match) || timed_out;

   // Compare the captured retirement effect against the current table entry
   always_comb begin
      match = 1'b1;
      case (ent_kind)
         KIND_REG:  match = cap_rf_we && (cap_rf_waddr == ent_idx[REG_AW-1:0])
                            && (cap_rf_wdata == ent_value);
         KIND_MEM:  match = cap_dm_we && (cap_dm_addr == ent_idx)
                            && (cap_dm_wdata == ent_value);
         KIND_PC:   match = (cap_pc == ent_value);
         default:   match = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Next-state sequencing of the step loop
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nx = (n_start == '0) ? S_DONE : S_STEP;
         S_STEP:         state_nx = S_WAIT;
         S_WAIT: begin
            if (core.commit)              state_nx = S_CHECK;
            else if (timer == TIMER_LAST) state_nx = S_ADVANCE;
         end
         S_CHECK:        state_nx = S_ADVANCE;
         S_ADVANCE:      state_nx = ((step_inc == n_steps) || (step_err && stop_mode))
                                    ? S_DONE : S_STEP;
         default:        state_nx = S_IDLE;
      endcase
   end

   // Run bookkeeping, commit timer, bus capture and error recording
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_steps      <= '0;
         step         <= '0;
         stop_mode    <= 1'b0;
         timer        <= '0;
         step_err     <= 1'b0;
         err_count    <= '0;
         fail_step    <= '0;
         cap_rf_we    <= 1'b0;
         cap_rf_waddr <= '0;
         cap_rf_wdata <= '0;
         cap_dm_we    <= 1'b0;
         cap_dm_addr  <= '0;
         cap_dm_wdata <= '0;
         cap_pc       <= '0;
      end else begin
         if (accept_start) begin
            n_steps   <= n_start;
            stop_mode <= stop_on_fail;
            step      <= '0;
            err_count <= '0;
            fail_step <= '0;
         end
         if (state == S_STEP) begin
            timer    <= '0;
            step_err <= 1'b0;
         end else if (state == S_WAIT) begin
            timer <= timer + TW'(1);
         end
         if (got_commit) begin
            cap_rf_we    <= core.rf_we;
            cap_rf_waddr <= core.rf_waddr;
            cap_rf_wdata <= core.rf_wdata;
            cap_dm_we    <= core.dm_we;
            cap_dm_addr  <= core.dm_addr;
            cap_dm_wdata <= core.dm_wdata;
            cap_pc       <= core.pc_next;
         end
         if (record_err) begin
            step_err  <= 1'b1;
            err_count <= sat_inc(err_count);
            if (err_count == '0) fail_step <= step[AW-1:0];
         end
         if (state == S_ADVANCE) step <= step_inc;
      end
   end
endmodule

// File: tb/tb_step_checker.sv
// tb/tb_step_checker.sv - self-checking bench for step_checker with a stepped-core model
`timescale 1ns/1ps
module tb_step_checker;
   import step_checker_pkg::*;

   localparam int DW = 16, PW = 16, RA = 3, DEPTH = 16, TO = 8, AW = 4;

   typedef struct {
      int lat;
      int pass_v;
      int err;
      int fs;
      int pulses;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic exp_we = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [1:0] exp_kind = '0;
   logic [PW-1:0] exp_idx = '0;
   logic [DW-1:0] exp_value = '0;
   logic start = 1'b0;
   logic [AW:0] num_steps = '0;
   logic stop_on_fail = 1'b0;
   logic busy, done, pass;
   logic [7:0] err_count;
   logic [AW-1:0] fail_step;

   step_checker_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .REG_AW(RA)) cif ();

   step_checker #(
      .DATA_WIDTH(DW), .PC_WIDTH(PW), .REG_AW(RA), .DEPTH(DEPTH), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .exp_we(exp_we), .exp_addr(exp_addr), .exp_kind(exp_kind),
      .exp_idx(exp_idx), .exp_value(exp_value),
      .start(start), .num_steps(num_steps), .stop_on_fail(stop_on_fail),
      .core(cif),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_step(fail_step)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t sb[$];

   // per-step core responses
   logic          rsp_rf_we [16];
   logic [RA-1:0] rsp_rf_waddr [16];
   logic [DW-1:0] rsp_rf_wdata [16];
   logic          rsp_dm_we [16];
   logic [PW-1:0] rsp_dm_addr [16];
   logic [DW-1:0] rsp_dm_wdata [16];
   logic [PW-1:0] rsp_pc [16];
   int            rsp_d [16];
   int run_id = 0;
   int pulses = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   task automatic set_rsp(input int k, input logic rwe, input int ra, input int rd,
                          input logic dwe, input int da, input int dd, input int pc);
      rsp_rf_we[k]    = rwe;
      rsp_rf_waddr[k] = ra[RA-1:0];
      rsp_rf_wdata[k] = rd[DW-1:0];
      rsp_dm_we[k]    = dwe;
      rsp_dm_addr[k]  = da[PW-1:0];
      rsp_dm_wdata[k] = dd[DW-1:0];
      rsp_pc[k]       = pc[PW-1:0];
   endtask

   task automatic set_delays(input int d);
      for (int k = 0; k < 16; k++) rsp_d[k] = d;
   endtask

   task automatic load(input int a, input logic [1:0] kind, input int idx, input int val);
      @(negedge clk);
      exp_we = 1'b1;
      exp_addr = a[AW-1:0];
      exp_kind = kind;
      exp_idx = idx[PW-1:0];
      exp_value = val[DW-1:0];
      @(negedge clk);
      exp_we = 1'b0;
   endtask

   // Start a run, push its expected outcome, then pop and compare once done appears
   task automatic run(input int nsteps, input logic sof, input int e_lat, input int e_pass,
                      input int e_err, input int e_fs, input int e_pulses, input string tag);
      exp_t e;
      int lat;
      int base;
      e.lat = e_lat; e.pass_v = e_pass; e.err = e_err; e.fs = e_fs; e.pulses = e_pulses;
      sb.push_back(e);
      run_id++;
      base = pulses;
      @(negedge clk);
      num_steps = nsteps[AW:0];
      stop_on_fail = sof;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      check_eq({tag, ".busy"}, busy, (nsteps != 0) ? 1 : 0);
      while (!done && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      check_eq({tag, ".done"}, done, 1);
      check_eq({tag, ".lat"}, lat, e.lat);
      check_eq({tag, ".pass"}, pass, e.pass_v);
      check_eq({tag, ".err"}, err_count, e.err);
      check_eq({tag, ".fail_step"}, fail_step, e.fs);
      check_eq({tag, ".pulses"}, pulses - base, e.pulses);
   endtask

   // Stepped-core model: commits rsp_d cycles after each step_en (0 = never)
   initial begin : core_model
      int seen_run;
      int mk;
      int k;
      seen_run = 0;
      mk = 0;
      cif.commit = 1'b0; cif.rf_we = 1'b0; cif.rf_waddr = '0; cif.rf_wdata = '0;
      cif.dm_we = 1'b0; cif.dm_addr = '0; cif.dm_wdata = '0; cif.pc_next = '0;
      forever begin
         @(negedge clk);
         if (run_id != seen_run) begin
            seen_run = run_id;
            mk = 0;
         end
         if (cif.step_en === 1'b1) begin
            k = mk & 15;
            mk++;
            pulses++;
            if (rsp_d[k] > 0) begin
               repeat (rsp_d[k]) @(negedge clk);
               cif.rf_we = rsp_rf_we[k]; cif.rf_waddr = rsp_rf_waddr[k];
               cif.rf_wdata = rsp_rf_wdata[k];
               cif.dm_we = rsp_dm_we[k]; cif.dm_addr = rsp_dm_addr[k];
               cif.dm_wdata = rsp_dm_wdata[k]; cif.pc_next = rsp_pc[k];
               cif.commit = 1'b1;
               @(negedge clk);
               cif.commit = 1'b0; cif.rf_we = 1'b0; cif.dm_we = 1'b0;
            end
         end
      end
   end

   initial begin : main
      for (int k = 0; k < 16; k++) set_rsp(k, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      set_delays(1);
      repeat (2) @(negedge clk);
      check_eq("reset.step_en", cif.step_en, 0);
      check_eq("reset.busy", busy, 0);
      check_eq("reset.done", done, 0);
      check_eq("reset.pass", pass, 0);
      check_eq("reset.err", err_count, 0);
      check_eq("reset.fail_step", fail_step, 0);
      reset_n = 1'b1;

      load(0, KIND_REG, 0, 16'h0001);
      load(1, KIND_REG, 1, 16'h0002);
      load(2, KIND_REG, 2, 16'h0003);
      for (int k = 0; k < 3; k++) set_rsp(k, 1'b1, k, k + 1, 1'b0, 0, 0, 0);
      run(3, 1'b0, 13, 1, 0, 0, 3, "reg_ok");
      set_rsp(1, 1'b1, 1, 5, 1'b0, 0, 0, 0);
      run(3, 1'b0, 13, 0, 1, 1, 3, "reg_bad");
      run(3, 1'b1, 9, 0, 1, 1, 2, "reg_stop");
      set_rsp(1, 1'b1, 1, 2, 1'b0, 0, 0, 0);
      set_rsp(2, 1'b1, 3, 3, 1'b0, 0, 0, 0);
      run(3, 1'b0, 13, 0, 1, 2, 3, "reg_addr");
      set_rsp(2, 1'b1, 2, 3, 1'b0, 0, 0, 0);

      set_delays(0);
      run(1, 1'b0, 11, 0, 1, 0, 1, "timeout");
      set_delays(8);
      run(1, 1'b0, 12, 1, 0, 0, 1, "commit_at_limit");
      set_delays(9);
      run(1, 1'b0, 11, 0, 1, 0, 1, "commit_late");

      // table write and start both ignored while a run is in flight
      set_delays(0);
      fork
         run(1, 1'b0, 11, 0, 1, 0, 1, "busy_ignore");
         begin
            repeat (4) @(negedge clk);
            load(0, KIND_PC, 0, 16'hdead);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join

      // reset in the WAIT of step 2 after step 1 has already failed
      set_rsp(1, 1'b1, 1, 5, 1'b0, 0, 0, 0);
      rsp_d[0] = 1; rsp_d[1] = 1; rsp_d[2] = 0;
      run_id++;
      @(negedge clk);
      num_steps = 3; stop_on_fail = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("pre_rst.busy", busy, 1);
      check_eq("pre_rst.err", err_count, 1);
      check_eq("pre_rst.fail_step", fail_step, 1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("rst.step_en", cif.step_en, 0);
      check_eq("rst.busy", busy, 0);
      check_eq("rst.done", done, 0);
      check_eq("rst.pass", pass, 0);
      check_eq("rst.err", err_count, 0);
      check_eq("rst.fail_step", fail_step, 0);
      @(negedge clk);
      reset_n = 1'b1;
      set_rsp(1, 1'b1, 1, 2, 1'b0, 0, 0, 0);
      set_delays(1);
      run(3, 1'b0, 13, 1, 0, 0, 3, "after_reset");

      load(0, KIND_MEM, 2, 16'h0003);
      load(1, KIND_PC, 0, 16'h000d);
      load(2, KIND_NONE, 0, 0);
      set_rsp(0, 1'b0, 0, 0, 1'b1, 2, 3, 0);
      set_rsp(1, 1'b0, 0, 0, 1'b0, 0, 0, 16'h000d);
      set_rsp(2, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      set_delays(2);
      run(3, 1'b0, 16, 1, 0, 0, 3, "mem_pc_none");
      set_rsp(0, 1'b0, 0, 0, 1'b1, 3, 3, 0);
      set_rsp(1, 1'b0, 0, 0, 1'b0, 0, 0, 16'h000e);
      run(3, 1'b0, 16, 0, 2, 0, 3, "mem_pc_bad");
      run(0, 1'b0, 1, 1, 0, 0, 0, "zero_steps");

      for (int a = 0; a < DEPTH; a++) load(a, KIND_NONE, 0, 0);
      set_delays(1);
      run(20, 1'b0, 65, 1, 0, 0, 16, "clamp");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/step_checker.md
# step_checker

Hardware self-checking stepper for the 16-bit RISC core: it issues single-step enables to the processor and, after each committed instruction, compares the architectural effect against a preloaded table of expected events. Each event is one of: register write, data-memory write or next-PC. It replaces the hand-written stepped bench sequence with a parametrised, synthesizable checker. Width, register count, table depth, timeout and stop-on-fail mode are all configurable. It sits beside the datapath, gating its clock enable and observing its writeback, store and PC-next buses.

## Interface
- DATA_WIDTH, 16, register/memory data width
- PC_WIDTH, 16, PC and data-memory address width
- REG_AW, 3, register-file address width
- DEPTH, 16, expected-event table entries (power of two)
- TIMEOUT, 8, max cycles from step_en to commit
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- exp_we  in  1  table write strobe
- exp_addr  in  log2(DEPTH)  table write index
- exp_kind  in  2  0=REG, 1=MEM, 2=PC, 3=NONE
- exp_idx  in  PC_WIDTH  REG: register number (low REG_AW bits); MEM: address; otherwise ignored
- exp_value  in  DATA_WIDTH  expected data / pc_next
- start  in  1  begin run (pulse)
- num_steps  in  log2(DEPTH)+1  steps to run
- stop_on_fail  in  1  halt at first mismatch
- step_en  out  1  one-cycle processor clock enable
- commit  in  1  processor retired the stepped instruction
- rf_we, rf_waddr[REG_AW], rf_wdata[DATA_WIDTH]  in  observed register write
- dm_we, dm_addr[PC_WIDTH], dm_wdata[DATA_WIDTH]  in  observed store
- pc_next  in  PC_WIDTH  observed next PC
- busy  out  1  run in progress
- done  out  1  run finished (held until next start)
- pass  out  1  valid with done; 1 = zero errors
- err_count  out  8  mismatches + timeouts, saturating at 255
- fail_step  out  log2(DEPTH)  index of first failing step

## Operation
- FSM states:
  - IDLE: start → latch n = min(num_steps, DEPTH); clear err_count, fail_step, done, pass; n=0 → DONE, else → STEP.
  - STEP: assert step_en for exactly one cycle, clear timer → WAIT.
  - WAIT: commit=1 → capture all observed buses → CHECK. Timer reaches TIMEOUT → record an error → ADVANCE.
  - CHECK: compare against entry[step] → ADVANCE.
  - ADVANCE: step+1. If step+1 == n, or (error && stop_on_fail) → DONE; else → STEP.
  - DONE: done=1; pass=(err_count==0); start → same as IDLE+start.
- Compare rules for each kind:
  - REG: pass iff rf_we && rf_waddr==idx[REG_AW-1:0] && rf_wdata==value.
  - MEM: pass iff dm_we && dm_addr==idx && dm_wdata==value.
  - PC: pass iff pc_next==value.
  - NONE: always pass.
- Error recording: the first error sets fail_step=step. Later errors only increment err_count, which saturates.
- Ignored inputs:
  - exp_we ignored while busy.
  - start ignored while busy.
  - commit ignored outside WAIT.
- Table has no reset and retains its contents across reset_n.

## Timing
- Reset values: step_en=0, busy=0, done=0, pass=0, err_count=0, fail_step=0, state IDLE, step=0.
- Reset is asynchronous; it aborts a run mid-step and drops step_en immediately.
- Table write takes effect on the clk edge with exp_we=1. The entry is readable the next cycle.
- Per-step latency: start→step_en 1 cycle. Then step_en(1) + commit wait (≥1) + CHECK(1) + ADVANCE(1), giving a minimum of 4 cycles per step.
- commit in the same cycle as step_en is not sampled; the earliest valid commit is the cycle after step_en.
- Timeout boundary: commit arriving in the cycle the timer hits TIMEOUT counts as a commit, not a timeout.
- busy=1 from the cycle after an accepted start until DONE is entered. done rises in the same cycle busy falls.

## Structure
- Package step_checker_pkg holds:
  - kind encodings KIND_REG/MEM/PC/NONE;
  - FSM state enum;
  - error-counter width constant.
- Sub-module step_expect_ram: DEPTH × (2+PC_WIDTH+DATA_WIDTH), synchronous write, asynchronous read.
- Top level contains the FSM, timer, capture registers and comparator.

## Test plan
- Load 3 entries: REG r0=0001, REG r1=0002, REG r2=0003. Model returns matching writes, commit 1 cycle after step_en. → done, pass=1, err_count=0, 3 step_en pulses.
- Same table, but step 1 returns rf_wdata=0005 with stop_on_fail=0. → pass=0, err_count=1, fail_step=1, all 3 steps run.
- Same mismatch with stop_on_fail=1. → done after step 1, only 2 step_en pulses.
- Model never asserts commit, TIMEOUT=8, n=1. → timeout error 8 cycles after step_en, err_count=1, fail_step=0.
- Entries MEM addr 2 = 0003, then PC = 000D, then NONE; n=3. → pass=1. Separately, num_steps=0 → done one cycle after start with pass=1.
- Assert reset_n low mid-WAIT. → all outputs return to reset values at once. Table contents survive; a rerun passes.
